// File: rtl/fetch_queue_pkg.sv
// Shared types and helpers for the fetch/decode instruction queue.
// The FETCH_QUEUE_BYPASS_EN option is handled in fetch_decode_queue.
package fetch_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus_four;
    logic [31:0] instruction;
  } fq_entry_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // The occupancy must be able to hold DEPTH itself, hence the extra bit.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x 96-bit entry storage: one synchronous write port and one
// asynchronous read port. It holds no control state.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  fq_entry_t         wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output fq_entry_t         rdata_o
);

  fq_entry_t mem_q [DEPTH];

  // NOTE: storage is left unreset on purpose; the count and pointers decide
  // which entries are valid, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode with valid/ready on both sides
// and a flush on taken branches. Define FETCH_QUEUE_BYPASS_EN for 0-cycle bypass.
module fetch_decode_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic [31:0]                   Instruction_in,
  input  logic [31:0]                   PCPlusFour_in,
  input  logic [31:0]                   PC_in,
  input  logic                          In_Valid,
  output logic                          In_Ready,
  input  logic                          Flush,
  output logic [31:0]                   Instruction_out,
  output logic [31:0]                   PCPlusFour_out,
  output logic [31:0]                   PC_out,
  output logic                          Out_Valid,
  input  logic                          Out_Ready,
  output logic [count_width(DEPTH)-1:0] Count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = count_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  fq_entry_t in_entry, mem_rdata, head;
  logic      empty, bypass, out_valid, push, pop, wr_en;

  assign in_entry = '{pc: PC_in, pc_plus_four: PCPlusFour_in, instruction: Instruction_in};

  assign empty    = (count_q == '0);
  assign In_Ready = (count_q < FULL_CNT);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty & ~Flush & In_Valid;
`else
  assign bypass = 1'b0;
`endif

  // Flush hides the head from decode in the same cycle it is raised.
  assign out_valid = ~Flush & (~empty | bypass);

  // A bypassed entry that decode takes immediately is never stored.
  assign push  = In_Valid & In_Ready & ~(bypass & Out_Ready);
  assign pop   = out_valid & Out_Ready & ~empty;
  assign wr_en = push & ~Flush;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (Clock),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    head = bypass ? in_entry : mem_rdata;
    if (out_valid) begin
      Instruction_out = head.instruction;
      PCPlusFour_out  = head.pc_plus_four;
      PC_out          = head.pc;
    end else begin
      Instruction_out = NOP_WORD;
      PCPlusFour_out  = '0;
      PC_out          = '0;
    end
  end

  assign Out_Valid = out_valid;
  assign Count     = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed boundary cases plus
// randomized traffic compared every cycle against a queue-based model.
module tb_fetch_decode_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW    = count_width(DEPTH);

  logic          Clock, Reset_n;
  logic [31:0]   Instruction_in, PCPlusFour_in, PC_in;
  logic          In_Valid, In_Ready, Flush;
  logic [31:0]   Instruction_out, PCPlusFour_out, PC_out;
  logic          Out_Valid, Out_Ready;
  logic [CW-1:0] Count;

  fetch_decode_queue #(.DEPTH(DEPTH), .NOP_WORD(32'h0000_0000)) dut (
    .Clock           (Clock),
    .Reset_n         (Reset_n),
    .Instruction_in  (Instruction_in),
    .PCPlusFour_in   (PCPlusFour_in),
    .PC_in           (PC_in),
    .In_Valid        (In_Valid),
    .In_Ready        (In_Ready),
    .Flush           (Flush),
    .Instruction_out (Instruction_out),
    .PCPlusFour_out  (PCPlusFour_out),
    .PC_out          (PC_out),
    .Out_Valid       (Out_Valid),
    .Out_Ready       (Out_Ready),
    .Count           (Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;
  fq_entry_t model_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit model_bypass();
`ifdef FETCH_QUEUE_BYPASS_EN
    return (model_q.size() == 0) && !Flush && In_Valid;
`else
    return 1'b0;
`endif
  endfunction

  // Expected outputs follow directly from the occupancy and head of the model.
  task automatic compare_all();
    bit          byp;
    bit          exp_valid;
    fq_entry_t   hd;
    byp       = model_bypass();
    exp_valid = !Flush && (model_q.size() > 0 || byp);
    if (model_q.size() > 0) hd = model_q[0];
    else hd = '{pc: PC_in, pc_plus_four: PCPlusFour_in, instruction: Instruction_in};
    check("count",    32'(Count),    model_q.size());
    check("in_ready", 32'(In_Ready), (model_q.size() < DEPTH) ? 1 : 0);
    check("out_valid", 32'(Out_Valid), 32'(exp_valid));
    if (exp_valid) begin
      check("instr", Instruction_out, hd.instruction);
      check("pc",    PC_out,          hd.pc);
      check("pc4",   PCPlusFour_out,  hd.pc_plus_four);
    end else begin
      check("instr_empty", Instruction_out, 32'h0);
      check("pc_empty",    PC_out,          32'h0);
      check("pc4_empty",   PCPlusFour_out,  32'h0);
    end
  endtask

  task automatic drive(input bit iv, input bit ordy, input bit fl,
                       input logic [31:0] pc, input logic [31:0] instr);
    @(negedge Clock);
    In_Valid       = iv;
    Out_Ready      = ordy;
    Flush          = fl;
    PC_in          = pc;
    PCPlusFour_in  = pc + 32'd4;
    Instruction_in = instr;
    #1;
    compare_all();
  endtask

  task automatic tick();
    bit        byp, exp_valid, do_pop, do_push;
    fq_entry_t e;
    byp       = model_bypass();
    exp_valid = !Flush && (model_q.size() > 0 || byp);
    do_pop    = exp_valid && Out_Ready && (model_q.size() > 0);
    do_push   = In_Valid && (model_q.size() < DEPTH) && !(byp && Out_Ready);
    e = '{pc: PC_in, pc_plus_four: PCPlusFour_in, instruction: Instruction_in};
    @(posedge Clock);
    if (Flush) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
  endtask

  task automatic async_reset();
    @(negedge Clock);
    In_Valid  = 1'b0;
    Out_Ready = 1'b0;
    Flush     = 1'b0;
    #1 Reset_n = 1'b0;
    #1;
    check("rst_count",     32'(Count),     32'd0);
    check("rst_out_valid", 32'(Out_Valid), 32'd0);
    check("rst_in_ready",  32'(In_Ready),  32'd1);
    check("rst_instr",     Instruction_out, 32'h0);
    model_q.delete();
    #1 Reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_n = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0; Flush = 1'b0;
    PC_in = '0; PCPlusFour_in = '0; Instruction_in = '0;
    #2;
    check("reset_count",     32'(Count),      32'd0);
    check("reset_in_ready",  32'(In_Ready),   32'd1);
    check("reset_out_valid", 32'(Out_Valid),  32'd0);
    check("reset_instr",     Instruction_out, 32'h0);
    #10 Reset_n = 1'b1;

    drive(0, 0, 0, 32'h0, 32'h0); tick();

    // Fill to full with decode stalled; third push is refused.
    drive(1, 0, 0, 32'h00, 32'hA000_0000); tick();
    drive(1, 0, 0, 32'h04, 32'hA000_0004); tick();
    drive(1, 0, 0, 32'h08, 32'hA000_0008);
    check("full_count",    32'(Count),    32'd2);
    check("full_in_ready", 32'(In_Ready), 32'd0);
    check("full_pc",       PC_out,        32'h00);
    check("full_pc4",      PCPlusFour_out, 32'h04);
    tick();

    // Drain.
    drive(0, 1, 0, 32'h0, 32'h0);
    check("drain0_pc", PC_out, 32'h00);
    tick();
    drive(0, 1, 0, 32'h0, 32'h0);
    check("drain1_pc",       PC_out,   32'h04);
    check("drain1_in_ready", 32'(In_Ready), 32'd1);
    tick();
    drive(0, 0, 0, 32'h0, 32'h0);
    check("drained_count", 32'(Count),     32'd0);
    check("drained_valid", 32'(Out_Valid), 32'd0);
    tick();

    // Continuous stream with pointer wrap.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] pc;
      pc = 32'h10 + 32'(4 * i);
      drive(1, 1, 0, pc, 32'hB000_0000 | pc);
`ifdef FETCH_QUEUE_BYPASS_EN
      check("stream_pc",    PC_out,     pc);
      check("stream_count", 32'(Count), 32'd0);
`else
      if (i > 0) begin
        check("stream_pc",    PC_out,     pc - 32'd4);
        check("stream_count", 32'(Count), 32'd1);
      end
`endif
      tick();
    end
    drive(0, 1, 0, 32'h0, 32'h0); tick();

    // Flush with a full queue and a simultaneous push/pop.
    drive(1, 0, 0, 32'h50, 32'hC000_0050); tick();
    drive(1, 0, 0, 32'h54, 32'hC000_0054); tick();
    drive(1, 1, 1, 32'h58, 32'hC000_0058);
    check("flush_valid", 32'(Out_Valid), 32'd0);
    check("flush_pc",    PC_out,         32'h0);
    tick();
    drive(0, 0, 0, 32'h0, 32'h0);
    check("post_flush_count", 32'(Count),     32'd0);
    check("post_flush_valid", 32'(Out_Valid), 32'd0);
    tick();

`ifdef FETCH_QUEUE_BYPASS_EN
    drive(1, 1, 0, 32'h40, 32'hD000_0040);
    check("bypass_pc",    PC_out,         32'h40);
    check("bypass_valid", 32'(Out_Valid), 32'd1);
    check("bypass_count", 32'(Count),     32'd0);
    tick();
    drive(0, 0, 0, 32'h0, 32'h0);
    check("bypass_after_count", 32'(Count), 32'd0);
    tick();
`endif

    // Asynchronous reset with data held.
    drive(1, 0, 0, 32'h60, 32'hE000_0060); tick();
    async_reset();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit iv, ordy, fl;
      iv   = ($urandom % 4) != 0;
      ordy = ($urandom % 3) != 0;
      fl   = ($urandom % 20) == 0;
      drive(iv, ordy, fl, $urandom & 32'hFFFF_FFFC, $urandom);
      tick();
      if (i % 97 == 96) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
